instr_fetch_queue: RTL and testbench

Upstream fetch stage for the pipelined MIPS core. It generates sequential word addresses, runs a req/ack handshake with instruction memory, and buffers returned words with their PCs in a small prefetch FIFO. The decode stage pops from this FIFO through a valid/ready interface. A redirect from branch/jump resolution flushes the FIFO and restarts fetch at the target.

---
 rtl/instr_fetch_queue.sv | 103 ++++++++++
 tb/tb_instr_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch with req/ack memory handshake and prefetch FIFO
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       fd_valid,
  input  logic                       fd_ready,
  output logic [31:0]                fd_instr,
  output logic [31:0]                fd_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} stateT;

  stateT state, nextState;
  logic [31:0] fetchPc, nextFetchPc, target;
  logic [31:0] memInstr [DEPTH];
  logic [31:0] memPc [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr, nextRd;
  logic [CW-1:0] count, countAfter;
  logic ack, pop, push, loadAddr;

  assign imem_req = state != IDLE;
  assign fd_valid = count != '0;
  assign fq_count = count;

  // Handshake qualification, slot reservation and next fetch state; a pending
  // request already owns a slot, so only idle-time issue checks for space.
  always_comb begin
    target      = {redirect_pc[31:2], 2'b00};
    ack         = imem_req && imem_ack;
    pop         = fd_valid && fd_ready;
    push        = ack && state == REQ && !redirect_valid;
    countAfter  = count + CW'(push) - CW'(pop);
    nextRd      = rdPtr + 1'b1;
    nextFetchPc = redirect_valid ? target : push ? imem_addr + 32'd4 : fetchPc;
    nextState   = state;
    if (redirect_valid)
      nextState = (imem_req && !imem_ack) ? DISCARD : REQ;
    else if (state == IDLE)
      nextState = countAfter < CW'(DEPTH) ? REQ : IDLE;
    else if (ack)
      nextState = (state == DISCARD || countAfter < CW'(DEPTH)) ? REQ : IDLE;
    loadAddr = nextState == REQ && (state == IDLE || ack || redirect_valid);
  end

  // Fetch FSM, fetch PC and the held request address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetchPc   <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      state   <= nextState;
      fetchPc <= nextFetchPc;
      if (loadAddr) imem_addr <= nextFetchPc;
    end
  end

  // FIFO storage; written only on an accepted, non-flushed push
  always_ff @(posedge clock) begin
    if (push) begin
      memInstr[wrPtr] <= imem_rdata;
      memPc[wrPtr]    <= imem_addr;
    end
  end

  // FIFO pointers, occupancy and registered head; a redirect flushes everything
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      fd_instr <= '0;
      fd_pc    <= '0;
    end else if (redirect_valid) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= nextRd;
      count <= countAfter;
      if (push && (count == '0 || (pop && count == CW'(1)))) begin
        fd_instr <= imem_rdata;
        fd_pc    <= imem_addr;
      end else if (pop && count > CW'(1)) begin
        fd_instr <= memInstr[nextRd];
        fd_pc    <= memPc[nextRd];
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed self-checking bench for the fetch queue
module tb_instr_fetch_queue;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fd_valid;
  logic        fd_ready = 1'b0;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic [2:0]  fq_count;
  int nCmp = 0;
  int nBad = 0;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fd_valid(fd_valid), .fd_ready(fd_ready),
    .fd_instr(fd_instr), .fd_pc(fd_pc), .fq_count(fq_count)
  );

  always #5 clock = ~clock;

  // Memory contents: each word is its address scrambled with a fixed key
  assign imem_rdata = imem_addr ^ KEY;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset;
    reset_n = 1'b0;
    imem_ack = 1'b0;
    fd_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step;
    step;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step;
    nCmp++; if (imem_req !== 1'b0) begin nBad++; $display("FAIL reset_req: got %h want 0", imem_req); end
    nCmp++; if (imem_addr !== 32'h0) begin nBad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    nCmp++; if (fd_valid !== 1'b0) begin nBad++; $display("FAIL reset_valid: got %h want 0", fd_valid); end
    nCmp++; if (fd_instr !== 32'h0) begin nBad++; $display("FAIL reset_instr: got %h want 0", fd_instr); end
    nCmp++; if (fd_pc !== 32'h0) begin nBad++; $display("FAIL reset_pc: got %h want 0", fd_pc); end
    nCmp++; if (fq_count !== 3'd0) begin nBad++; $display("FAIL reset_count: got %0d want 0", fq_count); end
  endtask

  task automatic test_sequential;
    doReset;
    fd_ready = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      nCmp++; if (imem_req !== 1'b1) begin nBad++; $display("FAIL seq_req[%0d]: got %h want 1", i, imem_req); end
      nCmp++; if (imem_addr !== 32'(4 * i)) begin nBad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i)); end
      if (i > 0) begin
        nCmp++; if (fd_valid !== 1'b1) begin nBad++; $display("FAIL seq_valid[%0d]: got %h want 1", i, fd_valid); end
        nCmp++; if (fd_pc !== 32'(4 * (i - 1))) begin nBad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, fd_pc, 32'(4 * (i - 1))); end
        nCmp++; if (fd_instr !== (32'(4 * (i - 1)) ^ KEY)) begin nBad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, fd_instr, 32'(4 * (i - 1)) ^ KEY); end
        nCmp++; if (fq_count !== 3'd1) begin nBad++; $display("FAIL seq_count[%0d]: got %0d want 1", i, fq_count); end
      end
    end
  endtask

  task automatic test_full;
    int acks = 0;
    int maxCount = 0;
    doReset;
    imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) acks++;
      step;
      if (int'(fq_count) > maxCount) maxCount = int'(fq_count);
    end
    nCmp++; if (acks !== 4) begin nBad++; $display("FAIL full_acks: got %0d want 4", acks); end
    nCmp++; if (fq_count !== 3'd4) begin nBad++; $display("FAIL full_count: got %0d want 4", fq_count); end
    nCmp++; if (imem_req !== 1'b0) begin nBad++; $display("FAIL full_req: got %h want 0", imem_req); end
    nCmp++; if (fd_pc !== 32'h0) begin nBad++; $display("FAIL full_head: got %h want 0", fd_pc); end
    fd_ready = 1'b1;
    step;
    fd_ready = 1'b0;
    nCmp++; if (imem_req !== 1'b1) begin nBad++; $display("FAIL refill_req: got %h want 1", imem_req); end
    nCmp++; if (imem_addr !== 32'h10) begin nBad++; $display("FAIL refill_addr: got %h want 10", imem_addr); end
    nCmp++; if (fd_pc !== 32'h4) begin nBad++; $display("FAIL refill_head: got %h want 4", fd_pc); end
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) acks++;
      step;
      if (int'(fq_count) > maxCount) maxCount = int'(fq_count);
    end
    nCmp++; if (acks !== 1) begin nBad++; $display("FAIL refill_acks: got %0d want 1", acks); end
    nCmp++; if (maxCount !== 4) begin nBad++; $display("FAIL full_max: got %0d want 4", maxCount); end
    nCmp++; if (imem_req !== 1'b0) begin nBad++; $display("FAIL refill_idle: got %h want 0", imem_req); end
  endtask

  task automatic test_discard;
    doReset;
    fd_ready = 1'b1;
    step;
    step;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    step;
    redirect_valid = 1'b0;
    nCmp++; if (imem_req !== 1'b1) begin nBad++; $display("FAIL disc_req: got %h want 1", imem_req); end
    nCmp++; if (imem_addr !== 32'h0) begin nBad++; $display("FAIL disc_addr: got %h want 0", imem_addr); end
    nCmp++; if (fq_count !== 3'd0) begin nBad++; $display("FAIL disc_count: got %0d want 0", fq_count); end
    imem_ack = 1'b1;
    step;
    imem_ack = 1'b0;
    nCmp++; if (imem_addr !== 32'h100) begin nBad++; $display("FAIL disc_target: got %h want 100", imem_addr); end
    nCmp++; if (fd_valid !== 1'b0) begin nBad++; $display("FAIL disc_dropped: got %h want 0", fd_valid); end
    nCmp++; if (imem_req !== 1'b1) begin nBad++; $display("FAIL disc_rereq: got %h want 1", imem_req); end
    imem_ack = 1'b1;
    step;
    imem_ack = 1'b0;
    nCmp++; if (fd_pc !== 32'h100) begin nBad++; $display("FAIL disc_pc: got %h want 100", fd_pc); end
    nCmp++; if (fd_instr !== (32'h100 ^ KEY)) begin nBad++; $display("FAIL disc_instr: got %h want %h", fd_instr, 32'h100 ^ KEY); end
  endtask

  task automatic test_redirect_pop;
    doReset;
    fd_ready = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) step;
    nCmp++; if (fd_pc !== 32'h8) begin nBad++; $display("FAIL rp_head: got %h want 8", fd_pc); end
    nCmp++; if (imem_addr !== 32'hC) begin nBad++; $display("FAIL rp_addr: got %h want c", imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step;
    redirect_valid = 1'b0;
    nCmp++; if (fq_count !== 3'd0) begin nBad++; $display("FAIL rp_flush: got %0d want 0", fq_count); end
    nCmp++; if (fd_valid !== 1'b0) begin nBad++; $display("FAIL rp_valid: got %h want 0", fd_valid); end
    nCmp++; if (imem_addr !== 32'h40) begin nBad++; $display("FAIL rp_target: got %h want 40", imem_addr); end
    step;
    nCmp++; if (fd_pc !== 32'h40) begin nBad++; $display("FAIL rp_pc: got %h want 40", fd_pc); end
    nCmp++; if (fd_instr !== (32'h40 ^ KEY)) begin nBad++; $display("FAIL rp_instr: got %h want %h", fd_instr, 32'h40 ^ KEY); end
  endtask

  task automatic test_wrap;
    logic [31:0] expAddr [3];
    expAddr[0] = 32'hFFFF_FFF8;
    expAddr[1] = 32'hFFFF_FFFC;
    expAddr[2] = 32'h0000_0000;
    doReset;
    fd_ready = 1'b1;
    imem_ack = 1'b1;
    step;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nCmp++; if (imem_addr !== expAddr[i]) begin nBad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, imem_addr, expAddr[i]); end
      step;
      nCmp++; if (fd_pc !== expAddr[i]) begin nBad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, fd_pc, expAddr[i]); end
    end
  endtask

  task automatic test_async_reset;
    doReset;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) step;
    imem_ack = 1'b0;
    nCmp++; if (fq_count !== 3'd2) begin nBad++; $display("FAIL ar_pre_count: got %0d want 2", fq_count); end
    nCmp++; if (imem_addr !== 32'h8) begin nBad++; $display("FAIL ar_pre_addr: got %h want 8", imem_addr); end
    #2 reset_n = 1'b0;
    #1;
    nCmp++; if (imem_req !== 1'b0) begin nBad++; $display("FAIL ar_req: got %h want 0", imem_req); end
    nCmp++; if (imem_addr !== 32'h0) begin nBad++; $display("FAIL ar_addr: got %h want 0", imem_addr); end
    nCmp++; if (fq_count !== 3'd0) begin nBad++; $display("FAIL ar_count: got %0d want 0", fq_count); end
    nCmp++; if (fd_pc !== 32'h0) begin nBad++; $display("FAIL ar_pc: got %h want 0", fd_pc); end
    nCmp++; if (fd_instr !== 32'h0) begin nBad++; $display("FAIL ar_instr: got %h want 0", fd_instr); end
    step;
    reset_n = 1'b1;
    imem_ack = 1'b1;
    step;
    nCmp++; if (imem_req !== 1'b1) begin nBad++; $display("FAIL ar_restart_req: got %h want 1", imem_req); end
    nCmp++; if (imem_addr !== 32'h0) begin nBad++; $display("FAIL ar_restart_addr: got %h want 0", imem_addr); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_full;
    test_discard;
    test_redirect_pop;
    test_wrap;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
